// File: rtl/axis_fifo_pkg.sv
// Shared constants and helpers for the dual AXI-Stream FIFO bridge.
// The counter width is derived so a count can hold the full-FIFO value.
package axis_fifo_pkg;

    localparam int DEF_DATA_WIDTH    = 20;
    localparam int DEF_FIFO_DEPTH    = 512;
    localparam int DEF_AFULL_THRESH  = 480;
    localparam int DEF_AEMPTY_THRESH = 16;

    // {write, read} handshake pair observed in one cycle
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FWFT stream FIFO with exact occupancy, almost flags,
// optional store-and-forward gating and a synchronous flush.
module axis_sync_fifo
    import axis_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int PACKET_MODE   = 0,
    parameter int AFULL_THRESH  = DEF_AFULL_THRESH,
    parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH,
    localparam int CNT_W        = cnt_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rst_done,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_tdata,
    input  logic                  in_tvalid,
    input  logic                  in_tlast,
    output logic                  in_tready,
    output logic [DATA_WIDTH-1:0] out_tdata,
    output logic                  out_tvalid,
    output logic                  out_tlast,
    input  logic                  out_tready,
    output logic [CNT_W-1:0]      data_count,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int              PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_WIDTH:0]  mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [CNT_W-1:0]     pkt_count_r;
    logic [CNT_W-1:0]     count_nxt_s;
    logic [CNT_W-1:0]     pkt_count_nxt_s;
    logic [DATA_WIDTH:0]  rd_word_s;
    logic                 full_s;
    logic                 empty_s;
    logic                 pkt_ready_s;
    logic                 wr_s;
    logic                 rd_s;
    fifo_op_e             op_s;
    fifo_op_e             pkt_op_s;

    // Handshake qualification and FWFT output view of the head entry
    always_comb begin
        full_s  = (count_r == FULL_CNT);
        empty_s = (count_r == CNT_ZERO);
        // Packet mode releases data only once a tlast is stored, or when full to avoid deadlock
        if (PACKET_MODE != 0) begin
            pkt_ready_s = (pkt_count_r != CNT_ZERO) || full_s;
        end else begin
            pkt_ready_s = 1'b1;
        end
        in_tready  = rst_done && !full_s && !flush;
        out_tvalid = !empty_s && !flush && pkt_ready_s;
        rd_word_s  = mem_r[rd_ptr_r];
        if (rst_done) begin
            out_tdata = rd_word_s[DATA_WIDTH-1:0];
            out_tlast = rd_word_s[DATA_WIDTH];
        end else begin
            out_tdata = {DATA_WIDTH{1'b0}};
            out_tlast = 1'b0;
        end
        wr_s     = in_tvalid && in_tready;
        rd_s     = out_tvalid && out_tready;
        op_s     = fifo_op_e'({wr_s, rd_s});
        pkt_op_s = fifo_op_e'({wr_s && in_tlast, rd_s && out_tlast});
    end

    // Next occupancy and stored-packet counts
    always_comb begin
        count_nxt_s     = count_r;
        pkt_count_nxt_s = pkt_count_r;
        case (op_s)
            OP_WRITE: count_nxt_s = count_r + CNT_ONE;
            OP_READ:  count_nxt_s = count_r - CNT_ONE;
            default:  count_nxt_s = count_r;
        endcase
        case (pkt_op_s)
            OP_WRITE: pkt_count_nxt_s = pkt_count_r + CNT_ONE;
            OP_READ:  pkt_count_nxt_s = pkt_count_r - CNT_ONE;
            default:  pkt_count_nxt_s = pkt_count_r;
        endcase
    end

    // Pointer and counter state; flush wins over any handshake in its cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            pkt_count_r <= CNT_ZERO;
        end else if (flush) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            pkt_count_r <= CNT_ZERO;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r     <= count_nxt_s;
            pkt_count_r <= pkt_count_nxt_s;
        end
    end

    // Storage array, deliberately not reset or cleared by flush
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= {in_tlast, in_tdata};
        end
    end

    // Occupancy status derived directly from the count
    always_comb begin
        data_count   = count_r;
        almost_full  = (int'(count_r) >= AFULL_THRESH);
        almost_empty = (int'(count_r) <= AEMPTY_THRESH);
    end

endmodule

// File: rtl/axis_dual_fifo_bridge.sv
// DMA-facing bridge: independent MM2S and S2MM stream FIFOs sharing one clock
// and a reset-release qualifier that holds tready low for one cycle after reset.
module axis_dual_fifo_bridge
    import axis_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int PACKET_MODE   = 0,
    parameter int AFULL_THRESH  = DEF_AFULL_THRESH,
    parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH,
    localparam int CNT_W        = cnt_width(FIFO_DEPTH)
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] mm2s_tdata,
    output logic                  mm2s_tvalid,
    output logic                  mm2s_tlast,
    input  logic                  mm2s_tready,
    output logic [CNT_W-1:0]      mm2s_data_count,
    output logic                  mm2s_almost_full,
    output logic                  mm2s_almost_empty,
    input  logic                  mm2s_flush,
    input  logic [DATA_WIDTH-1:0] s2mm_tdata,
    input  logic                  s2mm_tvalid,
    input  logic                  s2mm_tlast,
    output logic                  s2mm_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [CNT_W-1:0]      s2mm_data_count,
    output logic                  s2mm_almost_full,
    output logic                  s2mm_almost_empty,
    input  logic                  s2mm_flush
);

    logic rst_done_r;

    // Goes high on the first clock edge after reset release
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rst_done_r <= 1'b0;
        end else begin
            rst_done_r <= 1'b1;
        end
    end

    axis_sync_fifo #(
        .DATA_WIDTH    (DATA_WIDTH),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .PACKET_MODE   (PACKET_MODE),
        .AFULL_THRESH  (AFULL_THRESH),
        .AEMPTY_THRESH (AEMPTY_THRESH)
    ) u_mm2s_fifo (
        .clk          (aclk),
        .rst_n        (aresetn),
        .rst_done     (rst_done_r),
        .flush        (mm2s_flush),
        .in_tdata     (s_axis_tdata),
        .in_tvalid    (s_axis_tvalid),
        .in_tlast     (s_axis_tlast),
        .in_tready    (s_axis_tready),
        .out_tdata    (mm2s_tdata),
        .out_tvalid   (mm2s_tvalid),
        .out_tlast    (mm2s_tlast),
        .out_tready   (mm2s_tready),
        .data_count   (mm2s_data_count),
        .almost_full  (mm2s_almost_full),
        .almost_empty (mm2s_almost_empty)
    );

    axis_sync_fifo #(
        .DATA_WIDTH    (DATA_WIDTH),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .PACKET_MODE   (PACKET_MODE),
        .AFULL_THRESH  (AFULL_THRESH),
        .AEMPTY_THRESH (AEMPTY_THRESH)
    ) u_s2mm_fifo (
        .clk          (aclk),
        .rst_n        (aresetn),
        .rst_done     (rst_done_r),
        .flush        (s2mm_flush),
        .in_tdata     (s2mm_tdata),
        .in_tvalid    (s2mm_tvalid),
        .in_tlast     (s2mm_tlast),
        .in_tready    (s2mm_tready),
        .out_tdata    (m_axis_tdata),
        .out_tvalid   (m_axis_tvalid),
        .out_tlast    (m_axis_tlast),
        .out_tready   (m_axis_tready),
        .data_count   (s2mm_data_count),
        .almost_full  (s2mm_almost_full),
        .almost_empty (s2mm_almost_empty)
    );

endmodule

// File: tb/tb_axis_dual_fifo_bridge.sv
// Bench for axis_dual_fifo_bridge: two instances (FWFT and packet mode, depth 8)
// checked against queue-based reference model plus hand-written vector tables.
module tb_axis_dual_fifo_bridge;

    localparam int DW    = 20;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int NP    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [NP-1:0][DW-1:0] in_d;
    logic [NP-1:0]         in_v;
    logic [NP-1:0]         in_l;
    logic [NP-1:0]         out_r;
    logic [NP-1:0]         fl;
    logic [NP-1:0][DW-1:0] out_d;
    logic [NP-1:0]         out_v;
    logic [NP-1:0]         out_l;
    logic [NP-1:0]         in_rdy;
    logic [NP-1:0][CW-1:0] cnt;
    logic [NP-1:0]         af;
    logic [NP-1:0]         ae;

    axis_dual_fifo_bridge #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PACKET_MODE(0),
        .AFULL_THRESH(6), .AEMPTY_THRESH(5)
    ) u_dut_fwft (
        .aclk(clk), .aresetn(rst_n),
        .s_axis_tdata(in_d[0]), .s_axis_tvalid(in_v[0]), .s_axis_tlast(in_l[0]), .s_axis_tready(in_rdy[0]),
        .mm2s_tdata(out_d[0]), .mm2s_tvalid(out_v[0]), .mm2s_tlast(out_l[0]), .mm2s_tready(out_r[0]),
        .mm2s_data_count(cnt[0]), .mm2s_almost_full(af[0]), .mm2s_almost_empty(ae[0]), .mm2s_flush(fl[0]),
        .s2mm_tdata(in_d[1]), .s2mm_tvalid(in_v[1]), .s2mm_tlast(in_l[1]), .s2mm_tready(in_rdy[1]),
        .m_axis_tdata(out_d[1]), .m_axis_tvalid(out_v[1]), .m_axis_tlast(out_l[1]), .m_axis_tready(out_r[1]),
        .s2mm_data_count(cnt[1]), .s2mm_almost_full(af[1]), .s2mm_almost_empty(ae[1]), .s2mm_flush(fl[1])
    );

    axis_dual_fifo_bridge #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PACKET_MODE(1),
        .AFULL_THRESH(6), .AEMPTY_THRESH(2)
    ) u_dut_pkt (
        .aclk(clk), .aresetn(rst_n),
        .s_axis_tdata(in_d[2]), .s_axis_tvalid(in_v[2]), .s_axis_tlast(in_l[2]), .s_axis_tready(in_rdy[2]),
        .mm2s_tdata(out_d[2]), .mm2s_tvalid(out_v[2]), .mm2s_tlast(out_l[2]), .mm2s_tready(out_r[2]),
        .mm2s_data_count(cnt[2]), .mm2s_almost_full(af[2]), .mm2s_almost_empty(ae[2]), .mm2s_flush(fl[2]),
        .s2mm_tdata(in_d[3]), .s2mm_tvalid(in_v[3]), .s2mm_tlast(in_l[3]), .s2mm_tready(in_rdy[3]),
        .m_axis_tdata(out_d[3]), .m_axis_tvalid(out_v[3]), .m_axis_tlast(out_l[3]), .m_axis_tready(out_r[3]),
        .s2mm_data_count(cnt[3]), .s2mm_almost_full(af[3]), .s2mm_almost_empty(ae[3]), .s2mm_flush(fl[3])
    );

    // Reference model: one queue of {tlast, tdata} per path
    logic [DW:0] q[NP][$];
    bit          rdm;
    int          pm   [NP] = '{0, 0, 1, 1};
    int          afth [NP] = '{6, 6, 6, 6};
    int          aeth [NP] = '{5, 5, 2, 2};
    bit          wr_m [NP];
    bit          rd_m [NP];
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        bit          v;
        logic [DW-1:0] d;
        bit          r;
        bit          f;
        int          ecnt;
        bit          etv;
        bit          etr;
    } vec_t;
    vec_t tbl[14];

    function automatic vec_t mk(bit v, int d, bit r, bit f, int ecnt, bit etv, bit etr);
        vec_t x;
        x.v = v; x.d = DW'(d); x.r = r; x.f = f; x.ecnt = ecnt; x.etv = etv; x.etr = etr;
        return x;
    endfunction

    task automatic chk(input string nm, input int p, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s path%0d: got 0x%0h expected 0x%0h at %0t", nm, p, act, exp, $time);
        end
    endtask

    function automatic int pkts(int p);
        int n = 0;
        foreach (q[p][i]) if (q[p][i][DW]) n++;
        return n;
    endfunction

    function automatic bit exp_rdy(int p);
        return rdm && (q[p].size() < DEPTH) && !fl[p];
    endfunction

    function automatic bit exp_val(int p);
        return (q[p].size() != 0) && !fl[p] && (pm[p] == 0 || pkts(p) > 0 || q[p].size() == DEPTH);
    endfunction

    task automatic check_all();
        for (int p = 0; p < NP; p++) begin
            chk("tready", p, 32'(in_rdy[p]), 32'(exp_rdy(p)));
            chk("tvalid", p, 32'(out_v[p]), 32'(exp_val(p)));
            chk("count", p, 32'(cnt[p]), 32'(q[p].size()));
            chk("almost_full", p, 32'(af[p]), 32'(q[p].size() >= afth[p]));
            chk("almost_empty", p, 32'(ae[p]), 32'(q[p].size() <= aeth[p]));
            if (q[p].size() > 0) begin
                chk("tdata", p, 32'(out_d[p]), 32'(q[p][0][DW-1:0]));
                chk("tlast", p, 32'(out_l[p]), 32'(q[p][0][DW]));
            end
            wr_m[p] = in_v[p] && exp_rdy(p);
            rd_m[p] = exp_val(p) && out_r[p];
        end
    endtask

    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        for (int p = 0; p < NP; p++) begin
            if (fl[p]) begin
                q[p].delete();
            end else begin
                if (rd_m[p]) void'(q[p].pop_front());
                if (wr_m[p]) q[p].push_back({in_l[p], in_d[p]});
            end
        end
        if (rst_n) rdm = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle();
        in_d = '0; in_v = '0; in_l = '0; out_r = '0; fl = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        #2;
        rdm = 1'b0;
        for (int p = 0; p < NP; p++) q[p].delete();
        for (int p = 0; p < NP; p++) begin
            chk("rst_tready", p, 32'(in_rdy[p]), 32'd0);
            chk("rst_tvalid", p, 32'(out_v[p]), 32'd0);
            chk("rst_count", p, 32'(cnt[p]), 32'd0);
            chk("rst_afull", p, 32'(af[p]), 32'd0);
            chk("rst_aempty", p, 32'(ae[p]), 32'd1);
            chk("rst_tdata", p, 32'(out_d[p]), 32'd0);
            chk("rst_tlast", p, 32'(out_l[p]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        idle();
        // FWFT path 0: five writes, fill to full, one-read recovery, flush at 6
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 1);
        tbl[1]  = mk(1, 2, 0, 0, 1, 1, 1);
        tbl[2]  = mk(1, 3, 0, 0, 2, 1, 1);
        tbl[3]  = mk(1, 4, 0, 0, 3, 1, 1);
        tbl[4]  = mk(1, 5, 0, 0, 4, 1, 1);
        tbl[5]  = mk(0, 0, 0, 0, 5, 1, 1);
        tbl[6]  = mk(1, 6, 0, 0, 5, 1, 1);
        tbl[7]  = mk(1, 7, 0, 0, 6, 1, 1);
        tbl[8]  = mk(1, 8, 0, 0, 7, 1, 1);
        tbl[9]  = mk(1, 9, 0, 0, 8, 1, 0);
        tbl[10] = mk(0, 0, 1, 0, 8, 1, 0);
        tbl[11] = mk(0, 0, 1, 0, 7, 1, 1);
        tbl[12] = mk(1, 10, 1, 1, 6, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 1);

        #1;
        do_reset();

        for (int i = 0; i < 14; i++) begin
            idle();
            in_v[0] = tbl[i].v; in_d[0] = tbl[i].d; out_r[0] = tbl[i].r; fl[0] = tbl[i].f;
            #1;
            chk("tbl_count", i, 32'(cnt[0]), 32'(tbl[i].ecnt));
            chk("tbl_tvalid", i, 32'(out_v[0]), 32'(tbl[i].etv));
            chk("tbl_tready", i, 32'(in_rdy[0]), 32'(tbl[i].etr));
            step();
        end

        // Steady read+write at count 3 across pointer wrap
        idle();
        for (int k = 0; k < 3; k++) begin
            in_v[0] = 1'b1; in_d[0] = DW'(32'h100 + k);
            step();
        end
        for (int k = 0; k < 20; k++) begin
            in_v[0] = 1'b1; out_r[0] = 1'b1; in_d[0] = DW'(32'h200 + k);
            #1;
            chk("rw3_count", k, 32'(cnt[0]), 32'd3);
            step();
        end
        idle();
        out_r[0] = 1'b1;
        for (int k = 0; k < 4; k++) step();

        // Packet mode: tvalid held until the tlast word is stored
        idle();
        for (int k = 0; k < 4; k++) begin
            in_v[2] = 1'b1; in_d[2] = DW'(32'h300 + k); in_l[2] = (k == 3);
            #1;
            chk("pkt_hold_tvalid", k, 32'(out_v[2]), 32'd0);
            step();
        end
        idle();
        #1;
        chk("pkt_release_tvalid", 2, 32'(out_v[2]), 32'd1);
        out_r[2] = 1'b1;
        for (int k = 0; k < 5; k++) step();

        // Packet mode: full without tlast forces cut-through
        idle();
        for (int k = 0; k < DEPTH; k++) begin
            in_v[2] = 1'b1; in_d[2] = DW'(32'h400 + k);
            #1;
            chk("pkt_fill_tvalid", k, 32'(out_v[2]), 32'd0);
            step();
        end
        idle();
        #1;
        chk("pkt_full_tvalid", 2, 32'(out_v[2]), 32'd1);
        chk("pkt_full_count", 2, 32'(cnt[2]), 32'(DEPTH));
        out_r[2] = 1'b1;
        step();
        idle();
        step();
        fl[2] = 1'b1;
        step();
        idle();
        step();

        // Randomised traffic on all four paths
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < NP; p++) begin
                in_v[p]  = ($urandom_range(0, 9) < 7);
                in_d[p]  = DW'($urandom);
                in_l[p]  = ($urandom_range(0, 3) == 0);
                out_r[p] = ($urandom_range(0, 9) < ((c / 150) % 2 == 0 ? 6 : 3));
                fl[p]    = ($urandom_range(0, 49) == 0);
            end
            step();
        end

        // Reset mid-stream
        for (int c = 0; c < 10; c++) begin
            for (int p = 0; p < NP; p++) begin
                in_v[p] = 1'b1; in_d[p] = DW'($urandom); in_l[p] = 1'b0;
                out_r[p] = 1'b0; fl[p] = 1'b0;
            end
            step();
        end
        do_reset();
        for (int c = 0; c < 30; c++) begin
            for (int p = 0; p < NP; p++) begin
                in_v[p]  = $urandom_range(0, 1) != 0;
                in_d[p]  = DW'($urandom);
                in_l[p]  = ($urandom_range(0, 2) == 0);
                out_r[p] = $urandom_range(0, 1) != 0;
                fl[p]    = 1'b0;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
